// File: rtl/ov7670_frame_sched.sv
// Triple-buffer frame scheduler and burst arbiter for the OV7670 capture path.
// One memory burst port is shared between the camera writer and the display reader.
//
// state    | meaning
// IDLE     | waiting for sensor init to complete
// ARB      | choosing the next burst (holds while memory is busy)
// WR_BURST | write burst in flight, waiting for MEM_DONE
// RD_BURST | read burst in flight, waiting for MEM_DONE
module ov7670_frame_sched #(
    parameter int BURST_LEN    = 256,
    parameter int FRAME_BURSTS = 1200,
    parameter int ADDR_W       = 22
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic              INIT_DONE,
    input  logic              WR_VSYNC,
    input  logic              WR_REQ,
    input  logic              RD_VSYNC,
    input  logic              RD_REQ,
    input  logic              MEM_BUSY,
    input  logic              MEM_DONE,
    output logic              MEM_WR_START,
    output logic              MEM_RD_START,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              WR_GNT,
    output logic              RD_GNT,
    output logic [1:0]        WR_BANK,
    output logic [1:0]        RD_BANK,
    output logic              FRAME_VALID,
    output logic              WR_FRAME,
    output logic              RD_FRAME
);

    localparam int IDX_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int BL_SH = $clog2(BURST_LEN);
    localparam int OFF_W = ADDR_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BURSTS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_RD   = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       last_done;
    logic             wr_active;
    logic             rd_active;
    logic             wr_vs_pend;
    logic             rd_vs_pend;
    logic             rr_last_wr;

    logic       init_ok;
    logic       wr_q;
    logic       rd_q;
    logic       arb_go;
    logic       gnt_wr;
    logic       gnt_rd;
    logic       wr_done;
    logic       rd_done;
    logic       wr_discard;
    logic       rd_discard;
    logic       wr_complete;
    logic       rd_complete;
    logic       wr_vs_now;
    logic       wr_vs_defer;
    logic       rd_vs_now;
    logic       rd_vs_defer;
    logic       valid_now;
    logic [1:0] last_done_n;
    logic [1:0] rd_bank_n;
    logic       rd_active_n;
    logic [1:0] excl_bank;
    logic [1:0] wr_bank_n;

    function automatic logic [ADDR_W-1:0] burst_addr(input logic [1:0] bank,
                                                     input logic [IDX_W-1:0] idx);
        logic [OFF_W-1:0] off;
        off = OFF_W'(idx) << BL_SH;
        return {bank, off};
    endfunction

    always_comb begin
        init_ok     = INIT_DONE | (state != S_IDLE);
        wr_q        = WR_REQ & wr_active;
        rd_q        = RD_REQ & rd_active;
        arb_go      = (state == S_ARB) & ~MEM_BUSY;
        gnt_rd      = arb_go & rd_q & (~wr_q | rr_last_wr);
        gnt_wr      = arb_go & wr_q & ~gnt_rd;
        wr_done     = (state == S_WR) & MEM_DONE;
        rd_done     = (state == S_RD) & MEM_DONE;
        // A vsync during (or granted with) a burst discards that burst at its MEM_DONE.
        wr_discard  = wr_done & (wr_vs_pend | WR_VSYNC);
        rd_discard  = rd_done & (rd_vs_pend | RD_VSYNC);
        wr_complete = wr_done & ~wr_discard & (wr_idx == LAST_IDX);
        rd_complete = rd_done & ~rd_discard & (rd_idx == LAST_IDX);
        wr_vs_now   = WR_VSYNC & init_ok & (state != S_WR) & ~gnt_wr;
        wr_vs_defer = WR_VSYNC & init_ok & (((state == S_WR) & ~MEM_DONE) | gnt_wr);
        valid_now   = FRAME_VALID | wr_complete;
        last_done_n = wr_complete ? WR_BANK : last_done;
        rd_vs_now   = RD_VSYNC & (state != S_RD) & ~gnt_rd & valid_now;
        rd_vs_defer = RD_VSYNC & rd_active & (((state == S_RD) & ~MEM_DONE) | gnt_rd);

        rd_bank_n   = RD_BANK;
        rd_active_n = rd_active;
        if (rd_vs_now) begin
            rd_bank_n   = last_done_n;
            rd_active_n = 1'b1;
        end
        if (rd_discard) begin
            rd_bank_n = last_done_n;
        end
        if (rd_complete) begin
            rd_active_n = 1'b0;
        end

        // Bank 3 never exists, so it stands for "no reader to avoid".
        excl_bank = rd_active_n ? rd_bank_n : 2'd3;
        wr_bank_n = WR_BANK;
        if (wr_complete) begin
            if ((WR_BANK != 2'd0) && (excl_bank != 2'd0)) begin
                wr_bank_n = 2'd0;
            end else if ((WR_BANK != 2'd1) && (excl_bank != 2'd1)) begin
                wr_bank_n = 2'd1;
            end else begin
                wr_bank_n = 2'd2;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            wr_idx       <= '0;
            rd_idx       <= '0;
            last_done    <= 2'd0;
            wr_active    <= 1'b0;
            rd_active    <= 1'b0;
            wr_vs_pend   <= 1'b0;
            rd_vs_pend   <= 1'b0;
            rr_last_wr   <= 1'b1;
            MEM_WR_START <= 1'b0;
            MEM_RD_START <= 1'b0;
            MEM_ADDR     <= '0;
            WR_GNT       <= 1'b0;
            RD_GNT       <= 1'b0;
            WR_BANK      <= 2'd0;
            RD_BANK      <= 2'd0;
            FRAME_VALID  <= 1'b0;
            WR_FRAME     <= 1'b0;
            RD_FRAME     <= 1'b0;
        end else begin
            MEM_WR_START <= 1'b0;
            MEM_RD_START <= 1'b0;
            WR_FRAME     <= 1'b0;
            RD_FRAME     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (INIT_DONE) begin
                        state <= S_ARB;
                    end
                end
                S_ARB: begin
                    if (gnt_rd) begin
                        state        <= S_RD;
                        MEM_RD_START <= 1'b1;
                        RD_GNT       <= 1'b1;
                        MEM_ADDR     <= burst_addr(RD_BANK, rd_idx);
                        rr_last_wr   <= 1'b0;
                    end else if (gnt_wr) begin
                        state        <= S_WR;
                        MEM_WR_START <= 1'b1;
                        WR_GNT       <= 1'b1;
                        MEM_ADDR     <= burst_addr(WR_BANK, wr_idx);
                        rr_last_wr   <= 1'b1;
                    end
                end
                S_WR: begin
                    if (MEM_DONE) begin
                        state  <= S_ARB;
                        WR_GNT <= 1'b0;
                    end
                end
                default: begin
                    if (MEM_DONE) begin
                        state  <= S_ARB;
                        RD_GNT <= 1'b0;
                    end
                end
            endcase

            if (WR_VSYNC && init_ok) begin
                wr_active <= 1'b1;
            end
            if (wr_vs_now) begin
                wr_idx <= '0;
            end
            if (wr_vs_defer) begin
                wr_vs_pend <= 1'b1;
            end
            if (wr_done) begin
                wr_vs_pend <= 1'b0;
                if (wr_discard) begin
                    wr_idx <= '0;
                end else if (wr_complete) begin
                    wr_idx      <= '0;
                    WR_FRAME    <= 1'b1;
                    FRAME_VALID <= 1'b1;
                    last_done   <= WR_BANK;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end

            if (rd_vs_now) begin
                rd_idx <= '0;
            end
            if (rd_vs_defer) begin
                rd_vs_pend <= 1'b1;
            end
            if (rd_done) begin
                rd_vs_pend <= 1'b0;
                if (rd_discard) begin
                    rd_idx <= '0;
                end else if (rd_complete) begin
                    rd_idx   <= '0;
                    RD_FRAME <= 1'b1;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end

            WR_BANK   <= wr_bank_n;
            RD_BANK   <= rd_bank_n;
            rd_active <= rd_active_n;
        end
    end

endmodule

// File: doc/ov7670_frame_sched.md
# ov7670_frame_sched

Triple-buffer frame scheduler and burst arbiter for the OV7670 capture path. Shares one external-memory burst port between the camera write FIFO and the display read FIFO. Rotates three frame banks so the reader always scans a complete, untouched frame. Sits between the OV7670 capture/FIFO logic, the display read logic and the memory controller, and is enabled once sensor init completes.

## Interface
Parameters:
- BURST_LEN, 256: words per memory burst; must be a power of two.
- FRAME_BURSTS, 1200: bursts per frame (640x480x16 bit = 1200 x 256 words).
- ADDR_W, 22: memory word-address width. Requires FRAME_BURSTS*BURST_LEN <= 2^(ADDR_W-2).

Ports:
- SYS_CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- INIT_DONE  in  1  sensor configuration complete; no grants are issued before it is seen high.
- WR_VSYNC  in  1  one-cycle pulse marking camera frame start.
- WR_REQ  in  1  write FIFO holds at least BURST_LEN words.
- RD_VSYNC  in  1  one-cycle pulse marking display frame start.
- RD_REQ  in  1  read FIFO has room for BURST_LEN words.
- MEM_BUSY  in  1  memory controller is busy; no start is issued while high.
- MEM_DONE  in  1  one-cycle pulse when the current burst completes.
- MEM_WR_START  out  1  one-cycle write-burst start.
- MEM_RD_START  out  1  one-cycle read-burst start.
- MEM_ADDR  out  ADDR_W  burst base address: {bank[1:0], burst_idx*BURST_LEN}.
- WR_GNT  out  1  write FIFO owns the memory data path.
- RD_GNT  out  1  read FIFO owns the memory data path.
- WR_BANK  out  2  bank currently being written (0..2).
- RD_BANK  out  2  bank currently being read (0..2).
- FRAME_VALID  out  1  at least one complete frame exists.
- WR_FRAME  out  1  one-cycle pulse when a frame write completes.
- RD_FRAME  out  1  one-cycle pulse when a frame read completes.

## Operation
- FSM states:
  - IDLE: waits for INIT_DONE, then goes to ARB.
  - ARB: picks the next burst.
  - WR_BURST: waits for MEM_DONE, then returns to ARB.
  - RD_BURST: waits for MEM_DONE, then returns to ARB.
- Writer activity:
  - The writer becomes active on the first WR_VSYNC after INIT_DONE.
  - A write request is qualified only when WR_REQ is high and the writer is active.
- Reader activity:
  - On RD_VSYNC with FRAME_VALID=1, RD_BANK <= last_done and the reader becomes active.
  - On RD_VSYNC with FRAME_VALID=0, the reader stays inactive and RD_GNT is never asserted.
  - A read request is qualified only when RD_REQ is high and the reader is active.
- Arbitration in ARB with MEM_BUSY=0:
  - A single qualified request is granted.
  - When both are qualified, round-robin applies: the requester not granted last wins. The round-robin pointer resets to read-wins.
  - With MEM_BUSY=1, ARB holds.
- Burst counters:
  - wr_idx and rd_idx count 0..FRAME_BURSTS-1.
  - Each increments on MEM_DONE of its own burst type.
- Write frame completion (MEM_DONE with wr_idx = FRAME_BURSTS-1):
  - WR_FRAME pulses, last_done <= WR_BANK, FRAME_VALID <= 1, wr_idx <= 0.
  - WR_BANK <= the lowest bank index not equal to the old WR_BANK and not equal to the active RD_BANK.
  - The writer stays active; it does not wait for WR_VSYNC between frames.
- Read frame completion (MEM_DONE with rd_idx = FRAME_BURSTS-1):
  - RD_FRAME pulses, rd_idx <= 0, and the reader goes inactive until the next RD_VSYNC.
- Mid-frame WR_VSYNC:
  - wr_idx <= 0 and the partial frame is discarded; WR_BANK is unchanged.
  - If it arrives during WR_BURST, it is latched and applied at that burst's MEM_DONE; that burst is not counted.
- Mid-frame RD_VSYNC:
  - rd_idx <= 0 and the bank is re-latched from last_done.
  - During RD_BURST, the same deferral applies as for WR_VSYNC.
- Simultaneous write completion and RD_VSYNC: the reader takes the just-completed bank, and the writer's next bank excludes it.
- Invariant: WR_BANK != RD_BANK whenever the reader is active.

## Timing
- Reset values:
  - State = IDLE; all strobes and grants = 0.
  - WR_BANK = 0, RD_BANK = 0, last_done = 0.
  - FRAME_VALID = 0, MEM_ADDR = 0.
  - Counters = 0; writer and reader inactive.
- Reset mid-burst forces all of the above on the next edge; the memory controller's burst is abandoned.
- All outputs are registered. Start latency: a qualified request sampled in ARB drives START, GNT and MEM_ADDR on the next edge.
- MEM_ADDR is held stable from the START cycle through the MEM_DONE cycle.
- GNT is asserted from the START cycle through the MEM_DONE cycle inclusive, and drops on the following edge.
- WR_FRAME and RD_FRAME pulse in the cycle after MEM_DONE, together with the bank and counter updates.
- At least one ARB cycle separates consecutive bursts.
- A MEM_DONE that arrives while not in a BURST state is ignored.

## Test plan
Sim parameters: FRAME_BURSTS=4, BURST_LEN=8.
- Reset, INIT_DONE=1, WR_VSYNC, WR_REQ held, MEM_DONE 3 cycles after each start -> four write starts at addresses 0, 8, 16, 24 in bank 0; WR_FRAME pulses; WR_BANK=1; FRAME_VALID=1.
- After one frame, RD_VSYNC with WR_REQ and RD_REQ both held -> RD_BANK=0; starts alternate RD, WR, RD, WR; read addresses are {2'd0, 8*k}.
- Reader active on bank 0 while the writer completes a frame in bank 1 -> WR_BANK becomes 2, never 0; the next RD_VSYNC latches RD_BANK=1.
- WR_VSYNC asserted during the second write burst -> wr_idx restarts at 0 after MEM_DONE; the next write address is {bank, 0}; no WR_FRAME pulse.
- RD_VSYNC before any completed frame -> RD_GNT stays 0 and FRAME_VALID stays 0.
- Drive RST_N low during a RD_BURST -> on the next edge all outputs are at reset values; a later MEM_DONE produces no frame pulses.
